// File: rtl/bin_to_bcd.sv
// bin_to_bcd: sequential double-dabble converter from a BIN_W-bit unsigned
// value to 8 MAX7219 Code-B digits (bcd[3:0] = LSD, bcd[31:28] = MSD).
// One iteration per clock; done strobes BIN_W+1 clocks after start is taken.
// Values above 99,999,999 report overflow and show '-' on every digit.
// Optional build macro: BIN_TO_BCD_BLANK_EN -- replace leading zero digits
// (never the LSD) with the Code-B blank code 0xF.
module bin_to_bcd #(
  parameter int BIN_W = 27
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] value,
  output logic             busy,
  output logic             done,
  output logic [31:0]      bcd,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  localparam logic [31:0] MAX_DEC  = 32'd99_999_999;
  localparam logic [31:0] DASHES   = 32'hAAAA_AAAA;
  localparam logic [4:0]  LAST_IT  = 5'(BIN_W - 1);

  state_t             state;
  logic [31:0]        scratch;
  logic [BIN_W-1:0]   operand;
  logic [4:0]         iter;
  logic               ovf_q;
  logic [31:0]        adj;
  logic [31:0]        digits;

  // Add-3 correction on every BCD nibble that would reach 10 after doubling.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < 8; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  // Final digit pattern presented at FINISH (optionally with leading blanks).
  always_comb begin
    digits = scratch;
`ifdef BIN_TO_BCD_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      // Walk from the MSD down; the LSD (digit 0) is never blanked so that
      // a zero value still shows a single '0'.
      for (int i = 7; i >= 1; i--) begin
        if (lead && scratch[4*i +: 4] == 4'd0)
          digits[4*i +: 4] = 4'hF;
        else
          lead = 1'b0;
      end
    end
`endif
  end

  // Control FSM with registered outputs; reset wins over everything.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
      scratch  <= '0;
      operand  <= '0;
      iter     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            operand <= value;
            // Range is judged on the captured operand so later value changes
            // cannot influence the result.
            ovf_q   <= 32'(value) > MAX_DEC;
            scratch <= '0;
            iter    <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= {adj[30:0], operand[BIN_W-1]};
          operand <= {operand[BIN_W-2:0], 1'b0};
          if (iter == LAST_IT) begin
            state <= FINISH;
          end else begin
            iter <= iter + 5'd1;
          end
        end
        FINISH: begin
          bcd      <= ovf_q ? DASHES : digits;
          overflow <= ovf_q;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
